mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_starve_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data/interrupt memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2,
    OWN_I    = 2'd3
  } owner_t;

  typedef enum logic {
    ST_NORMAL    = 1'b0,
    ST_INTR_HOLD = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_STARVE_LIMIT  = 3;
  localparam logic [7:0]  DEF_INTR_VEC_ADDR = 8'h01;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants issued while fetch is waiting.
module mem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = LIMIT[W-1:0];

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A zero limit disables the fetch override entirely.
  assign at_limit = (LIMIT != 0) && (r_cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: interrupt > data > fetch with fetch anti-starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT  = DEF_STARVE_LIMIT,
  parameter logic [7:0]  INTR_VEC_ADDR = DEF_INTR_VEC_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_gnt,
  output logic       f_rvalid,
  output logic [7:0] f_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic [7:0] d_rdata,
  input  logic       i_req,
  output logic       i_gnt,
  output logic       i_rvalid,
  output logic [7:0] i_vector,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       stall_f
);

  arb_state_t r_state, w_state_nxt;
  owner_t     r_owner, w_owner_nxt;
  logic [7:0] r_vector;
  logic       w_at_limit;
  logic       w_inc, w_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_NORMAL;
      r_owner  <= OWN_NONE;
      r_vector <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (r_owner == OWN_I) r_vector <= mem_rdata;
    end
  end

  // Grants are combinational, so reset must gate them directly.
  always_comb begin
    f_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_gnt       = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_owner_nxt = OWN_NONE;
    w_state_nxt = r_state;
    if (reset) begin
      if (i_req && (r_state == ST_NORMAL)) begin
        i_gnt       = 1'b1;
        mem_addr    = INTR_VEC_ADDR;
        w_owner_nxt = OWN_I;
      end else if (f_req && (w_at_limit || !d_req)) begin
        f_gnt       = 1'b1;
        mem_addr    = f_addr;
        w_owner_nxt = OWN_F;
      end else if (d_req) begin
        d_gnt       = 1'b1;
        mem_addr    = d_addr;
        mem_we      = d_we;
        mem_wdata   = d_wdata;
        w_owner_nxt = d_we ? OWN_NONE : OWN_D;
      end
    end
    mem_en = f_gnt | d_gnt | i_gnt;
    case (r_state)
      ST_NORMAL:    if (i_gnt)  w_state_nxt = ST_INTR_HOLD;
      ST_INTR_HOLD: if (!i_req) w_state_nxt = ST_NORMAL;
      default:      w_state_nxt = ST_NORMAL;
    endcase
  end

  assign w_inc = d_gnt & f_req;
  assign w_clr = f_gnt | ~f_req;

  mem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (reset),
    .inc      (w_inc),
    .clr      (w_clr),
    .at_limit (w_at_limit)
  );

  assign f_rvalid = (r_owner == OWN_F);
  assign d_rvalid = (r_owner == OWN_D);
  assign i_rvalid = (r_owner == OWN_I);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign i_vector = i_rvalid ? mem_rdata : r_vector;
  assign stall_f  = f_req & ~f_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int unsigned LIM = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       f_req, d_req, d_we, i_req;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_gnt, f_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid;
  logic [7:0] f_rdata, d_rdata, i_vector;
  logic       mem_en, mem_we, stall_f;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT  (LIM),
    .INTR_VEC_ADDR (8'h01)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_vector(i_vector),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f)
  );

  // Environment memory, driven only by the DUT's command port.
  logic [7:0] ram [256];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // Reference model state: who=0 none, 1 fetch, 2 data, 3 interrupt.
  logic [7:0] ref_mem [256];
  bit         m_hold;
  int         m_cnt;
  int         m_pend;
  logic [7:0] m_pdata;
  logic [7:0] m_vec;
  int         m_who;
  logic [7:0] m_addr;
  logic [48:0] exp_b, obs_b, obs_now;

  assign obs_now = {f_gnt, d_gnt, i_gnt, mem_en, mem_we, mem_addr, mem_wdata, stall_f,
                    f_rvalid, d_rvalid, i_rvalid, f_rdata, d_rdata, i_vector};

  logic [2:0] s_gnt, s_rv;
  logic       s_we, s_stall, s_en;
  logic [7:0] s_addr, s_wdata, s_f_rdata, s_d_rdata, s_vec;

  task automatic model_reset();
    m_hold = 1'b0; m_cnt = 0; m_pend = 0; m_pdata = 8'h00; m_vec = 8'h00;
  endtask

  task automatic model_eval();
    int who;
    who = 0;
    if (reset) begin
      if (i_req && !m_hold)                                   who = 3;
      else if (f_req && ((LIM != 0 && m_cnt == LIM) || !d_req)) who = 1;
      else if (d_req)                                         who = 2;
    end
    m_who  = who;
    m_addr = (who == 1) ? f_addr : (who == 2) ? d_addr : (who == 3) ? 8'h01 : 8'h00;
    exp_b = {who == 1, who == 2, who == 3, who != 0, (who == 2) && d_we, m_addr,
             (who == 2) ? d_wdata : 8'h00, f_req && (who != 1),
             m_pend == 1, m_pend == 2, m_pend == 3,
             (m_pend == 1) ? m_pdata : 8'h00, (m_pend == 2) ? m_pdata : 8'h00,
             (m_pend == 3) ? m_pdata : m_vec};
  endtask

  task automatic model_commit();
    if (!reset) begin
      model_reset();
    end else begin
      if (m_pend == 3) m_vec = m_pdata;
      if (m_who == 3)  m_hold = 1'b1;
      else if (!i_req) m_hold = 1'b0;
      if (m_who == 1 || !f_req)              m_cnt = 0;
      else if (m_who == 2 && m_cnt < int'(LIM)) m_cnt = m_cnt + 1;
      if (m_who == 2 && d_we) begin
        ref_mem[d_addr] = d_wdata;
        m_pend = 0;
      end else if (m_who != 0) begin
        m_pend  = m_who;
        m_pdata = ref_mem[m_addr];
      end else begin
        m_pend = 0;
      end
    end
  endtask

  // Evaluate model, sample DUT mid-cycle, advance both across one clock edge.
  task automatic run_cycle();
    model_eval();
    @(negedge clk);
    obs_b = obs_now;
    s_gnt = {i_gnt, d_gnt, f_gnt}; s_rv = {i_rvalid, d_rvalid, f_rvalid};
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_stall = stall_f;
    s_f_rdata = f_rdata; s_d_rdata = d_rdata; s_vec = i_vector;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; d_we = 0; i_req = 0;
    f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    model_eval();
    tests_run++;
    if (obs_now !== exp_b || obs_now !== 49'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs_now, exp_b);
    end
    reset = 1'b1;
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b) begin
      tests_failed++;
      $display("FAIL reset_idle: got %h expected %h", obs_b, exp_b);
    end
  endtask

  task automatic test_fetch_read();
    ram[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    f_req = 1; f_addr = 8'h10;
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b || s_gnt !== 3'b001 || s_addr !== 8'h10 || s_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_grant: got gnt=%b addr=%h expected gnt=001 addr=10", s_gnt, s_addr);
    end
    f_req = 0;
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b || s_rv !== 3'b001 || s_f_rdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL fetch_rdata: got rv=%b rdata=%h expected rv=001 rdata=a5", s_rv, s_f_rdata);
    end
  endtask

  task automatic test_data_write();
    d_req = 1; d_we = 1; d_addr = 8'h80; d_wdata = 8'h3C; f_req = 1; f_addr = 8'h22;
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b || s_we !== 1'b1 || s_addr !== 8'h80 || s_wdata !== 8'h3C || s_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL data_write: got we=%b addr=%h wd=%h stall=%b expected 1 80 3c 1",
               s_we, s_addr, s_wdata, s_stall);
    end
    idle_inputs();
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b || s_rv !== 3'b000 || ram[8'h80] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL write_no_rvalid: got rv=%b mem=%h expected rv=000 mem=3c", s_rv, ram[8'h80]);
    end
  endtask

  task automatic test_starvation();
    int pat [8] = '{2, 2, 2, 1, 2, 2, 2, 1};
    idle_inputs();
    run_cycle();
    d_req = 1; d_we = 0; d_addr = 8'h30; f_req = 1; f_addr = 8'h40;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      tests_run++;
      if (obs_b !== exp_b || s_gnt !== ((pat[i] == 1) ? 3'b001 : 3'b010)) begin
        tests_failed++;
        $display("FAIL starve_seq[%0d]: got gnt=%b expected %s", i, s_gnt, (pat[i] == 1) ? "F" : "D");
      end
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_interrupt();
    int ni, nd;
    ram[8'h01] = 8'h40; ref_mem[8'h01] = 8'h40;
    ni = 0; nd = 0;
    i_req = 1; d_req = 1; d_addr = 8'h55;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      ni += int'(s_gnt[2]); nd += int'(s_gnt[1]);
      tests_run++;
      if (obs_b !== exp_b || (i == 0 && s_addr !== 8'h01) || (i == 1 && (s_rv[2] !== 1'b1 || s_vec !== 8'h40))) begin
        tests_failed++;
        $display("FAIL intr_cycle[%0d]: got %h expected %h", i, obs_b, exp_b);
      end
    end
    idle_inputs();
    run_cycle();
    tests_run++;
    if (obs_b !== exp_b || ni != 1 || nd != 4 || s_vec !== 8'h40) begin
      tests_failed++;
      $display("FAIL intr_summary: got i_gnts=%0d d_gnts=%0d vec=%h expected 1 4 40", ni, nd, s_vec);
    end
  endtask

  task automatic test_all_three();
    logic [2:0] pat [3] = '{3'b100, 3'b010, 3'b001};
    i_req = 1; d_req = 1; f_req = 1; d_addr = 8'h11; f_addr = 8'h12;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      tests_run++;
      if (obs_b !== exp_b || s_gnt !== pat[i]) begin
        tests_failed++;
        $display("FAIL all_three[%0d]: got gnt=%b expected %b", i, s_gnt, pat[i]);
      end
      if (s_gnt[2]) i_req = 0;
      if (s_gnt[1]) d_req = 0;
      if (s_gnt[0]) f_req = 0;
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_reset_midread();
    f_req = 1; f_addr = 8'h10;
    run_cycle();
    reset = 1'b0;
    model_reset();
    #2;
    model_eval();
    tests_run++;
    if (obs_now !== exp_b || f_rvalid !== 1'b0 || f_rdata !== 8'h00 || mem_en !== 1'b0 ||
        i_vector !== 8'h00 || stall_f !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", obs_now, exp_b);
    end
    idle_inputs();
    run_cycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      tests_run++;
      if (obs_b !== exp_b || s_rv !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_no_rvalid[%0d]: got rv=%b expected 000", i, s_rv);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_req   = ($urandom_range(0, 4) == 0);
      d_req   = ($urandom_range(0, 2) != 0);
      f_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1);
      f_addr  = 8'($urandom);
      d_addr  = 8'($urandom);
      d_wdata = 8'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      run_cycle();
      tests_run++;
      if (obs_b !== exp_b) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_b, exp_b);
      end
    end
    reset = 1'b1;
    idle_inputs();
    run_cycle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a] = 8'($urandom);
      ref_mem[a] = ram[a];
    end
    test_reset();
    test_fetch_read();
    test_data_write();
    test_starvation();
    test_interrupt();
    test_all_three();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
